// File: rtl/cache_bus_arbiter.sv
// Arbiter for the shared sram-like memory bus between the I-cache and D-cache miss ports.
// Optional round-robin arbitration on simultaneous requests when ARB_ROUND_ROBIN_EN is defined.
module cache_bus_arbiter #(
  parameter int unsigned I_STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t state;
  logic   addr_sent;
  logic   own_i;
  logic   own_d;
  logic   owner_req;
  logic   addr_hs;
  logic   data_hs;
  logic   pick_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 0 = D won last, 1 = I won last

  assign pick_i = i_req & (~d_req | ~last_grant);
`else
  logic [CNT_W-1:0] starve_cnt;

  assign pick_i = i_req & (~d_req | (starve_cnt == CNT_W'(I_STARVE_MAX)));
`endif

  assign own_i     = (state == GRANT_I);
  assign own_d     = (state == GRANT_D);
  assign owner_req = (own_i & i_req) | (own_d & d_req);

  // Bus side: owner fields muxed straight through; I is always a word read.
  assign bus_req   = owner_req & ~addr_sent & ~rst;
  assign bus_wr    = own_d & d_wr;
  assign bus_size  = own_d ? d_size : 2'b10;
  assign bus_addr  = own_d ? d_addr : i_addr;
  assign bus_wdata = own_d ? d_wdata : 32'h0;

  // Reset gates the handshakes so an in-flight response never leaks to a cache.
  assign addr_hs = bus_req & bus_addr_ok;
  assign data_hs = addr_sent & bus_data_ok & ~rst;

  assign i_addr_ok = own_i & addr_hs;
  assign d_addr_ok = own_d & addr_hs;
  assign i_data_ok = own_i & data_hs;
  assign d_data_ok = own_d & data_hs;
  assign i_rdata   = bus_rdata;
  assign d_rdata   = bus_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_sent <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            state <= GRANT_I;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`else
            starve_cnt <= '0;
`endif
          end else if (d_req) begin
            state <= GRANT_D;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`else
            if (i_req && (starve_cnt != CNT_W'(I_STARVE_MAX)))
              starve_cnt <= starve_cnt + CNT_W'(1);
`endif
          end
        end
        default: begin
          // Once the address is out, the owner is held until data returns.
          if (data_hs) begin
            state     <= IDLE;
            addr_sent <= 1'b0;
          end else if (addr_hs) begin
            addr_sent <= 1'b1;
          end else if (!addr_sent && !owner_req) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Scoreboard bench for cache_bus_arbiter: requester queues, a latency-configurable bus model,
// and an expected-transaction queue checked on every bus handshake.
module tb_cache_bus_arbiter;

  localparam int unsigned STARVE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_addr_ok, i_data_ok;
  logic        d_req = 1'b0, d_wr = 1'b0;
  logic [1:0]  d_size = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_addr_ok, d_data_ok;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;

  always #5 clk = ~clk;

  cache_bus_arbiter #(.I_STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
  );

  typedef struct {
    bit          side_d;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        d_q[$];
  txn_t        i_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  int          addr_lat = 1;
  int          data_lat = 2;
  bit          stray_dok = 0;
  bit          dok_with_aok = 0;
  bit          busy = 0;
  int          wait_cnt = 0;
  int          dcnt = 0;
  logic [31:0] cur_rdata = '0;

  bit          pend_valid = 0;
  bit          pend_d = 0;
  bit          prev_dok = 0;
  bit          model_last_d = 1;
  logic [31:0] pend_rdata = '0;
  bit          exp_i, exp_d, hs;
  txn_t        e;

  // Requesters: each side presents its oldest outstanding request.
  always @(negedge clk) begin
    i_req  = (i_q.size() > 0);
    i_addr = i_req ? i_q[0].addr : 32'h0;
    d_req  = (d_q.size() > 0);
    if (d_req) begin
      d_wr = d_q[0].wr; d_size = d_q[0].size; d_addr = d_q[0].addr; d_wdata = d_q[0].wdata;
    end else begin
      d_wr = 1'b0; d_size = 2'b00; d_addr = 32'h0; d_wdata = 32'h0;
    end
  end

  // Bus model: accepts an address after addr_lat waiting cycles, returns data data_lat cycles later.
  always @(negedge clk) begin
    #2;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (rst) begin
      busy = 0; wait_cnt = 0;
    end else if (stray_dok) begin
      bus_data_ok = 1'b1;
      bus_rdata   = 32'hDEADBEEF;
    end else if (busy) begin
      if (dcnt == data_lat) begin
        bus_data_ok = 1'b1; bus_rdata = cur_rdata; busy = 0;
      end else dcnt++;
    end else if (bus_req === 1'b1) begin
      if (wait_cnt == addr_lat) begin
        bus_addr_ok = 1'b1; busy = 1; dcnt = 1; wait_cnt = 0;
        cur_rdata = (exp_q.size() > 0) ? exp_q[0].rdata : 32'h0BAD0BAD;
        if (dok_with_aok) begin bus_data_ok = 1'b1; bus_rdata = 32'hFEEDF00D; end
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    #4;
    if (pend_valid || prev_dok || rst) begin
      n_tests++;
      if (bus_req !== 1'b0) begin
        n_fail++; $display("FAIL bus_req_quiet: got %b want 0", bus_req);
      end
    end
    exp_i = pend_valid && !pend_d && bus_data_ok && !rst;
    exp_d = pend_valid &&  pend_d && bus_data_ok && !rst;
    n_tests++;
    if (i_data_ok !== exp_i || d_data_ok !== exp_d) begin
      n_fail++; $display("FAIL data_ok: got i=%b d=%b want i=%b d=%b", i_data_ok, d_data_ok, exp_i, exp_d);
    end
    if (exp_i) begin
      n_tests++;
      if (i_rdata !== pend_rdata) begin
        n_fail++; $display("FAIL i_rdata: got %h want %h", i_rdata, pend_rdata);
      end
    end
    if (exp_d) begin
      n_tests++;
      if (d_rdata !== pend_rdata) begin
        n_fail++; $display("FAIL d_rdata: got %h want %h", d_rdata, pend_rdata);
      end
    end
    prev_dok = exp_i || exp_d;
    if (prev_dok) pend_valid = 0;
    hs = (bus_req === 1'b1) && (bus_addr_ok === 1'b1);
    if (hs) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL unexpected_txn: addr %h wr %b", bus_addr, bus_wr);
      end else begin
        e = exp_q.pop_front();
        if (bus_addr !== e.addr || bus_wr !== e.wr || bus_size !== e.size ||
            (e.wr && bus_wdata !== e.wdata) || i_addr_ok !== !e.side_d || d_addr_ok !== e.side_d) begin
          n_fail++;
          $display("FAIL bus_txn: got addr %h wr %b size %b wdata %h aok i%b d%b want addr %h wr %b size %b wdata %h side_d %b",
                   bus_addr, bus_wr, bus_size, bus_wdata, i_addr_ok, d_addr_ok, e.addr, e.wr, e.size, e.wdata, e.side_d);
        end
        pend_valid = 1; pend_d = e.side_d; pend_rdata = e.rdata; model_last_d = e.side_d;
        if (e.side_d && d_q.size() > 0) void'(d_q.pop_front());
        if (!e.side_d && i_q.size() > 0) void'(i_q.pop_front());
      end
    end else begin
      n_tests++;
      if (i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0) begin
        n_fail++; $display("FAIL addr_ok_spurious: got i=%b d=%b want 0 0", i_addr_ok, d_addr_ok);
      end
    end
    if (rst) begin pend_valid = 0; prev_dok = 0; model_last_d = 1; end
  end

  function automatic txn_t mk(bit side_d, logic wr, logic [1:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata);
    txn_t t;
    t.side_d = side_d; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (exp_q.size() == 0 && !pend_valid && i_q.size() == 0 && d_q.size() == 0) begin
        ok = 1; break;
      end
    end
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_tests++;
    if (bus_req !== 1'b0 || i_addr_ok !== 1'b0 || d_addr_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got bus_req %b aok %b%b want 000", bus_req, i_addr_ok, d_addr_ok);
    end
    n_tests++;
    if (i_data_ok !== 1'b0 || d_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_dok: got %b%b want 00", i_data_ok, d_data_ok);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (bus_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got bus_req %b want 0", bus_req);
    end
  endtask

  task automatic test_single_i();
    bit ok;
    txn_t t;
    addr_lat = 1; data_lat = 2;
    t = mk(0, 1'b0, 2'b10, 32'hBFC00000, 32'h0, 32'h12345678);
    exp_q.push_back(t); i_q.push_back(t);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_i_timeout: got pending want drained"); end
  endtask

  task automatic test_d_over_i();
    bit ok;
    txn_t td, ti;
    addr_lat = 0; data_lat = 1; dok_with_aok = 1;
    td = mk(1, 1'b1, 2'b00, 32'h80000004, 32'h000000AB, 32'h0);
    ti = mk(0, 1'b0, 2'b10, 32'hBFC00040, 32'h0, 32'hCAFE0001);
    d_q.push_back(td); i_q.push_back(ti);
    exp_q.push_back(td); exp_q.push_back(ti);
    wait_drain(ok);
    dok_with_aok = 0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL d_over_i_timeout: got pending want drained"); end
  endtask

  // Expected grant order comes from a small arbitration model starting with starve_cnt = 0.
  task automatic test_back_to_back(input int ni, input int nd);
    bit ok, pick_i, last_d;
    int ri, rd, cnt, ki, kd;
    txn_t ti[$], td[$];
    addr_lat = 0; data_lat = 1;
    for (int k = 0; k < ni; k++) ti.push_back(mk(0, 1'b0, 2'b10, 32'hBFC00100 + 32'(4*k), 32'h0, $urandom));
    for (int k = 0; k < nd; k++)
      td.push_back(mk(1, k[0], 2'b10, 32'h80001000 + 32'(4*k), $urandom, $urandom));
    ri = ni; rd = nd; cnt = 0; ki = 0; kd = 0; last_d = model_last_d;
    while (ri > 0 || rd > 0) begin
      if (ri > 0 && rd > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_i = last_d;
`else
        pick_i = (cnt == STARVE);
`endif
      end else pick_i = (ri > 0);
      if (pick_i) begin
        exp_q.push_back(ti[ki]); ki++; ri--; cnt = 0; last_d = 0;
      end else begin
        if (ri > 0 && cnt < STARVE) cnt++;
        exp_q.push_back(td[kd]); kd++; rd--; last_d = 1;
      end
    end
    foreach (ti[k]) i_q.push_back(ti[k]);
    foreach (td[k]) d_q.push_back(td[k]);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL back_to_back_timeout: got pending want drained"); end
  endtask

  task automatic test_drop();
    bit ok;
    txn_t td, ti;
    addr_lat = 3; data_lat = 1;
    td = mk(1, 1'b0, 2'b10, 32'h80002000, 32'h0, 32'h0);
    ti = mk(0, 1'b0, 2'b10, 32'hBFC00200, 32'h0, 32'h5A5A0001);
    d_q.push_back(td); i_q.push_back(ti);
    exp_q.push_back(ti);
    step(); step();
    d_q.delete();
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drop_timeout: got pending want drained"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    txn_t t, t2;
    addr_lat = 0; data_lat = 20;
    t = mk(0, 1'b0, 2'b10, 32'hBFC00300, 32'h0, 32'h11110000);
    i_q.push_back(t); exp_q.push_back(t);
    ok = 0;
    for (int c = 0; c < 50 && !ok; c++) begin step(); ok = pend_valid; end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid_addr_timeout: got no addr handshake want one"); end
    i_q.delete();
    rst = 1'b1;
    step();
    n_tests++;
    if (bus_req !== 1'b0 || i_data_ok !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outputs: got bus_req %b i_data_ok %b want 0 0", bus_req, i_data_ok);
    end
    rst = 1'b0;
    step();
    stray_dok = 1;
    step();
    stray_dok = 0;
    data_lat = 2;
    t2 = mk(1, 1'b0, 2'b01, 32'h80003002, 32'h0, 32'h77665544);
    d_q.push_back(t2); exp_q.push_back(t2);
    wait_drain(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid_timeout: got pending want drained"); end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_d_over_i();
    test_back_to_back(1, 6);
    test_back_to_back(1, 5);
    test_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
Shares the single sram-like memory bus (toward the AXI bridge) between the I-cache miss port and the D-cache miss/write-back port.
- One transaction is outstanding at a time.
- Once granted, the winner owns the bus until its data_ok returns.
- Fixed D-over-I priority, bounded by an I-side starvation counter.
- Sits between i_cache/d_cache and the AXI interface.

Parameters:
I_STARVE_MAX, 4, consecutive D grants allowed while an I request waits; the next arbitration then goes to I (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  reset
i_req  in  1  I-cache memory request (read only)
i_addr  in  32  I-cache word address
i_rdata  out  32  read data to I-cache
i_addr_ok  out  1  I address accepted
i_data_ok  out  1  I data returned
d_req  in  1  D-cache memory request
d_wr  in  1  D request is a write
d_size  in  2  D access size
d_addr  in  32  D address
d_wdata  in  32  D write data
d_rdata  out  32  read data to D-cache
d_addr_ok  out  1  D address accepted
d_data_ok  out  1  D data/write-ack returned
bus_req  out  1  request to bus
bus_wr  out  1  write flag to bus
bus_size  out  2  size to bus (2'b10 for I)
bus_addr  out  32  address to bus
bus_wdata  out  32  write data to bus
bus_rdata  in  32  read data from bus
bus_addr_ok  in  1  bus accepted address
bus_data_ok  in  1  bus returned data

Behaviour:
- Reset: reset rst, synchronous, active-high; clock clk.
  - state=IDLE, addr_sent=0, starve_cnt=0.
  - All *_ok outputs and bus_req are 0.
- States:
  - IDLE: no grant. Arbitration per cycle:
    - d_req only -> GRANT_D.
    - i_req only -> GRANT_I.
    - Both -> GRANT_I if starve_cnt==I_STARVE_MAX, else GRANT_D.
    - Neither -> stay IDLE.
  - GRANT_I / GRANT_D: the owner's req/wr/size/addr/wdata are muxed combinationally onto bus_*.
    - bus_req = owner_req & ~addr_sent.
    - Non-owner sees addr_ok=0 and data_ok=0.
- Addr phase:
  - owner addr_ok = bus_req & bus_addr_ok.
  - On that cycle addr_sent<=1.
- Data phase:
  - owner data_ok = addr_sent & bus_data_ok.
  - That cycle: addr_sent<=0, state<=IDLE.
  - Next arbitration happens in the following cycle (1-cycle bubble between transactions).
- rdata: i_rdata = d_rdata = bus_rdata unconditionally; only meaningful with the respective data_ok.
- Sizes: GRANT_I forces bus_wr=0 and bus_size=2'b10. GRANT_D passes d_wr and d_size through.
- starve_cnt (4-bit):
  - Increments on entry to GRANT_D while i_req=1, saturating at I_STARVE_MAX.
  - Clears on entry to GRANT_I.
  - Unchanged otherwise.
- Boundary conditions:
  - Owner drops req before addr_ok (addr_sent=0): return to IDLE next cycle; no transaction recorded.
  - Owner drops req after addr_sent: ignored; the arbiter still waits for bus_data_ok.
  - bus_data_ok is ignored while addr_sent=0, including in IDLE. A stray data_ok after a mid-transaction reset is dropped.
  - bus_addr_ok and bus_data_ok in the same cycle with addr_sent=0: only addr_ok is honoured. The bus guarantees data_ok no earlier than the cycle after addr_ok.
  - Reset mid-transaction: immediate return to IDLE; no ok pulses are generated.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - starve_cnt and I_STARVE_MAX are unused.
  - A 1-bit last_grant register (reset 0 = D) records the most recent winner.
  - On simultaneous requests, the side not granted last wins.
  - Single requests behave as in the base mode.
- Undefined: fixed D priority with the starvation counter, as specified above.

Test Plan:
- i_req alone, addr 0xBFC00000, bus addr_ok at cycle 2, data_ok at cycle 4 with rdata 0x12345678 -> bus_size=2'b10, bus_wr=0, single i_addr_ok, i_data_ok with i_rdata=0x12345678, d_*_ok stay 0.
- d_req wr=1 size=2'b00 addr 0x80000004 wdata 0xAB, simultaneous i_req -> D wins; bus carries D fields; I waits; I is granted the cycle after d_data_ok+1.
- i_req held high, d_req back-to-back for 6 transactions, I_STARVE_MAX=4 -> 4 D grants, then I granted, then D resumes; starve_cnt back to 0.
- d_req asserted then dropped before bus_addr_ok -> no bus transaction completes; state returns to IDLE; pending i_req granted next.
- rst asserted while addr_sent=1, then bus_data_ok pulses -> no i/d data_ok; state IDLE; subsequent request completes normally.
- ARB_ROUND_ROBIN_EN defined, both req continuously -> grants alternate D,I,D,I.
